// File: rtl/burst_main_mem.sv
// -----------------------------------------------------------------------------
// burst_main_mem
//
// Purpose:
//   Word-addressed backing store behind a byte-address window that starts at
//   BASE_ADDR. It sits between the fetch/load-store stages and the bench
//   loader, in the core clock domain.
//   - Supports single-beat and burst transfers. A burst is incrementing or
//     wraps inside its own aligned block.
//   - Writes are masked per byte lane.
//   - Reads return through a READ_LATENCY-deep pipeline with a valid strobe.
//   - An access outside the window raises err. A write in error is dropped.
//     A read in error returns zero.
//   - Dropping enable during a burst stalls it. The beat is not consumed and
//     the address does not advance.
//
// Handshake:
//   In IDLE, a rising edge with enable=1 accepts a request. addr, wren,
//   acc_size and wrap are latched on that edge, and beat 0 executes on that
//   same edge. For a multi-beat burst the block leaves IDLE and busy rises.
//   From then on, each edge with enable=1 consumes one beat. While busy=1,
//   request fields are ignored; only data_in and byte_en still matter. After
//   the final beat busy falls, and a new request may be presented on the
//   first edge that sees busy=0. Nothing is queued.
//
// Ports:
//   clock       in   rising-edge clock
//   reset       in   asynchronous, active-high; memory contents are kept
//   enable      in   request qualifier / burst beat enable
//   addr        in   byte address (low log2(DATA_WIDTH/8) bits ignored)
//   wren        in   1 = write, 0 = read (sampled at acceptance)
//   acc_size    in   0 -> 1 beat, k>0 -> 2^(k+1) beats
//   wrap        in   1 = wrap burst, 0 = incrementing (sampled at acceptance)
//   byte_en     in   write lane mask, lane 0 = data_in[0:7] (bit 0 is MSB)
//   data_in     in   write data, one word per beat
//   data_out    out  read data, holds its value when data_valid=0
//   data_valid  out  data_out carries a read beat this cycle
//   busy        out  burst in progress
//   err         out  out-of-window beat (write: one cycle after the beat;
//                    read: aligned with that beat's data_valid)
// -----------------------------------------------------------------------------
module burst_main_mem #(
  parameter int                    DATA_WIDTH   = 32,
  parameter int                    ADDR_WIDTH   = 32,
  parameter int                    DEPTH_WORDS  = 262144,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR    = 32'h80020000,
  parameter int                    ACC_W        = 2,
  parameter int                    READ_LATENCY = 1
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      enable,
  input  logic [ADDR_WIDTH-1:0]     addr,
  input  logic                      wren,
  input  logic [ACC_W-1:0]          acc_size,
  input  logic                      wrap,
  input  logic [0:DATA_WIDTH/8-1]   byte_en,
  input  logic [0:DATA_WIDTH-1]     data_in,
  output logic [0:DATA_WIDTH-1]     data_out,
  output logic                      data_valid,
  output logic                      busy,
  output logic                      err
);

  localparam int NB     = DATA_WIDTH / 8;
  localparam int OFF_W  = $clog2(NB);
  localparam int IDX_W  = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  // The largest burst code is 2^ACC_W - 1, which gives 2^(2^ACC_W) beats.
  // BEAT_W bits are enough to hold that beat count.
  localparam int MAX_K  = (2 ** ACC_W) - 1;
  localparam int BEAT_W = MAX_K + 2;
  localparam logic [ADDR_WIDTH-1:0] DEPTH_A = ADDR_WIDTH'(DEPTH_WORDS);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_WBURST = 2'd1,
    S_RBURST = 2'd2
  } state_t;

  // ---------------------------------------------------------------------------
  // State and latched request
  // ---------------------------------------------------------------------------
  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [ADDR_WIDTH-1:0]  r_start;    // word address of beat 0
  logic [BEAT_W-1:0]      r_mask;     // beats - 1 (also the wrap-block mask)
  logic [BEAT_W-1:0]      r_beat;     // index of the next beat to execute
  logic [BEAT_W-1:0]      w_beat_nxt;
  logic                   r_wren;
  logic                   r_wrap;

  // Storage is not reset; it keeps its contents across reset.
  logic [0:DATA_WIDTH-1]  r_mem [DEPTH_WORDS];

  // Read pipeline: stage 0 is the array sample taken on the beat edge.
  logic [READ_LATENCY-1:0] r_pv;
  logic [READ_LATENCY-1:0] r_pe;
  logic [0:DATA_WIDTH-1]   r_pd [READ_LATENCY];
  logic                    r_werr;

  // ---------------------------------------------------------------------------
  // Request decode
  // ---------------------------------------------------------------------------
  logic                   w_idle;
  logic [ADDR_WIDTH-1:0]  w_req_start;
  logic [BEAT_W-1:0]      w_req_mask;

  assign w_idle      = (r_state == S_IDLE);
  assign w_req_start = addr >> OFF_W;

  always_comb begin
    w_req_mask = '0;
    if (acc_size != '0) begin
      w_req_mask = BEAT_W'((1 << (int'(acc_size) + 1)) - 1);
    end
  end

  // ---------------------------------------------------------------------------
  // Current beat address
  // In IDLE, beat 0 is built straight from the request inputs so that it can
  // execute on the acceptance edge. In a burst, it comes from the latched copy.
  // ---------------------------------------------------------------------------
  logic [ADDR_WIDTH-1:0]  w_cur_start;
  logic [BEAT_W-1:0]      w_cur_mask;
  logic [BEAT_W-1:0]      w_cur_i;
  logic                   w_cur_wrap;
  logic                   w_cur_wren;
  logic [ADDR_WIDTH-1:0]  w_mask_a;
  logic [ADDR_WIDTH-1:0]  w_inc_word;
  logic [ADDR_WIDTH-1:0]  w_beat_word;
  logic [ADDR_WIDTH-1:0]  w_beat_byte;
  logic [ADDR_WIDTH-1:0]  w_diff;
  logic                   w_oob;
  logic [IDX_W-1:0]       w_idx;
  logic                   w_wr_beat;
  logic                   w_rd_beat;

  assign w_cur_start = w_idle ? w_req_start : r_start;
  assign w_cur_mask  = w_idle ? w_req_mask  : r_mask;
  assign w_cur_i     = w_idle ? '0          : r_beat;
  assign w_cur_wrap  = w_idle ? wrap        : r_wrap;
  assign w_cur_wren  = w_idle ? wren        : r_wren;

  assign w_mask_a    = ADDR_WIDTH'(w_cur_mask);
  assign w_inc_word  = w_cur_start + ADDR_WIDTH'(w_cur_i);
  // A wrap burst keeps the block bits of the start word and lets only the
  // in-block index advance, modulo the beat count.
  assign w_beat_word = w_cur_wrap ? ((w_cur_start & ~w_mask_a) | (w_inc_word & w_mask_a))
                                  : w_inc_word;
  assign w_beat_byte = w_beat_word << OFF_W;

  // The subtraction is done at full address width. An address below the
  // base is rejected explicitly, so it never aliases into the window.
  assign w_diff      = w_beat_byte - BASE_ADDR;
  assign w_oob       = (w_beat_byte < BASE_ADDR) || ((w_diff >> OFF_W) >= DEPTH_A);
  assign w_idx       = w_diff[OFF_W +: IDX_W];

  // enable both accepts a request in IDLE and consumes a beat in a burst.
  assign w_wr_beat   = enable &  w_cur_wren & ~w_oob;
  assign w_rd_beat   = enable & ~w_cur_wren;

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    w_beat_nxt  = r_beat;
    case (r_state)
      S_IDLE: begin
        if (enable && (w_req_mask != '0)) begin
          w_state_nxt = wren ? S_WBURST : S_RBURST;
          w_beat_nxt  = BEAT_W'(1);
        end
      end
      S_WBURST, S_RBURST: begin
        if (enable) begin
          if (r_beat == r_mask) begin
            w_state_nxt = S_IDLE;
            w_beat_nxt  = '0;
          end else begin
            w_beat_nxt  = r_beat + BEAT_W'(1);
          end
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_beat_nxt  = '0;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_beat  <= '0;
      r_start <= '0;
      r_mask  <= '0;
      r_wren  <= 1'b0;
      r_wrap  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_beat  <= w_beat_nxt;
      if (w_idle && enable) begin
        r_start <= w_req_start;
        r_mask  <= w_req_mask;
        r_wren  <= wren;
        r_wrap  <= wrap;
      end
    end
  end

  assign busy = !w_idle;

  // ---------------------------------------------------------------------------
  // Storage write port (lane-masked). While reset is high, no beat executes.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (!reset && w_wr_beat) begin
      for (int j = 0; j < NB; j++) begin
        if (byte_en[j]) begin
          r_mem[w_idx][8*j +: 8] <= data_in[8*j +: 8];
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Read pipeline and error flags.
  // The array sample uses non-blocking semantics, so a write to the same word
  // on the same edge is not seen; the read returns the old word. Each stage
  // only takes new data when valid data arrives, so data_out holds its last
  // delivered word through any gap.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_pv   <= '0;
      r_pe   <= '0;
      r_werr <= 1'b0;
      for (int k = 0; k < READ_LATENCY; k++) begin
        r_pd[k] <= '0;
      end
    end else begin
      r_werr  <= enable & w_cur_wren & w_oob;
      r_pv[0] <= w_rd_beat;
      r_pe[0] <= w_rd_beat & w_oob;
      if (w_rd_beat) begin
        r_pd[0] <= w_oob ? '0 : r_mem[w_idx];
      end
      for (int k = 1; k < READ_LATENCY; k++) begin
        r_pv[k] <= r_pv[k-1];
        r_pe[k] <= r_pe[k-1];
        if (r_pv[k-1]) begin
          r_pd[k] <= r_pd[k-1];
        end
      end
    end
  end

  assign data_valid = r_pv[READ_LATENCY-1];
  assign data_out   = r_pd[READ_LATENCY-1];
  assign err        = r_werr | r_pe[READ_LATENCY-1];

endmodule

// File: tb/tb_burst_main_mem.sv
// -----------------------------------------------------------------------------
// tb_burst_main_mem
//
// Testbench for burst_main_mem.
// - The driver tasks run bursts against a word model of the storage.
// - Every read beat pushes its expected {err, data} and its expected arrival
//   cycle into queues.
// - A monitor pops and compares one entry per data_valid.
// - Write error flags and busy are checked after every beat edge.
// -----------------------------------------------------------------------------
module tb_burst_main_mem;

  localparam int          DW    = 32;
  localparam int          AW    = 32;
  localparam int          DEPTH = 262144;
  localparam int          ACCW  = 2;
  localparam int          RL    = 1;
  localparam logic [31:0] BASE  = 32'h80020000;

  // ---------------------------------------------------------------------------
  // Clock / reset / DUT
  // ---------------------------------------------------------------------------
  logic            clock = 1'b0;
  logic            reset;
  logic            enable;
  logic [AW-1:0]   addr;
  logic            wren;
  logic [ACCW-1:0] acc_size;
  logic            wrap;
  logic [0:3]      byte_en;
  logic [0:DW-1]   data_in;
  logic [0:DW-1]   data_out;
  logic            data_valid;
  logic            busy;
  logic            err;

  always #5 clock = ~clock;

  burst_main_mem #(
    .DATA_WIDTH   (DW),
    .ADDR_WIDTH   (AW),
    .DEPTH_WORDS  (DEPTH),
    .BASE_ADDR    (BASE),
    .ACC_W        (ACCW),
    .READ_LATENCY (RL)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .enable     (enable),
    .addr       (addr),
    .wren       (wren),
    .acc_size   (acc_size),
    .wrap       (wrap),
    .byte_en    (byte_en),
    .data_in    (data_in),
    .data_out   (data_out),
    .data_valid (data_valid),
    .busy       (busy),
    .err        (err)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard state
  // ---------------------------------------------------------------------------
  int              n_cmp   = 0;
  int              n_mis   = 0;
  int              cyc_cnt = 0;
  logic [DW:0]     exp_q[$];
  int              cyc_q[$];
  logic [31:0]     model [int unsigned];
  logic [31:0]     wbuf  [16];
  logic [0:3]      cur_be;
  logic [DW:0]     mon_e;
  int              mon_c;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_cmp++;
    if (obs !== expv) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, expv, cyc_cnt);
    end
  endtask

  function automatic logic is_oob(input logic [31:0] b);
    return (b < BASE) || (((b - BASE) >> 2) >= 32'(DEPTH));
  endfunction

  function automatic logic [29:0] beat_word(input logic [29:0] w0, input int beats,
                                            input logic wp, input int i);
    int off;
    if (!wp) return w0 + 30'(i);
    off = int'(w0 % 30'(beats));
    return (w0 - 30'(off)) + 30'((off + i) % beats);
  endfunction

  // Monitor: one pop per delivered read beat.
  always @(posedge clock) begin
    cyc_cnt++;
    #1;
    if (data_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("spurious_valid", data_valid, 0);
      end else begin
        mon_e = exp_q.pop_front();
        mon_c = cyc_q.pop_front();
        check("rd_data",  data_out, mon_e[DW-1:0]);
        check("rd_err",   err,      mon_e[DW]);
        check("rd_cycle", cyc_cnt,  mon_c);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Driver
  // Runs one burst. stall_at/stall_len insert enable=0 cycles before beat
  // stall_at. abort_at asserts reset just before beat abort_at. A value of -1
  // disables either feature. Request fields are randomised after beat 0 to
  // show that only the latched copy matters.
  // ---------------------------------------------------------------------------
  task automatic run_burst(input logic wr, input logic [31:0] a, input logic [1:0] sz,
                           input logic wp, input int stall_at, input int stall_len,
                           input int abort_at);
    int          beats;
    logic [29:0] wa;
    logic [31:0] b;
    logic        oob;
    int unsigned idx;
    logic [31:0] nv;
    beats = (sz == 0) ? 1 : (1 << (sz + 1));
    for (int i = 0; i < beats; i++) begin
      if (i == abort_at) begin
        #2;
        reset = 1'b1;
        #1;
        check("abort_dout",  data_out,   0);
        check("abort_valid", data_valid, 0);
        check("abort_busy",  busy,       0);
        check("abort_err",   err,        0);
        exp_q.delete();
        cyc_q.delete();
        enable = 1'b0;
        @(posedge clock);
        #1;
        reset = 1'b0;
        return;
      end
      if (i == stall_at) begin
        repeat (stall_len) begin
          enable  = 1'b0;
          data_in = wbuf[i];
          addr    = $urandom;
          @(posedge clock);
          #1;
          check("stall_busy", busy, 1);
        end
      end
      wa  = beat_word(a[31:2], beats, wp, i);
      b   = {wa, 2'b00};
      oob = is_oob(b);
      idx = (b - BASE) >> 2;
      enable  = 1'b1;
      data_in = wbuf[i];
      byte_en = cur_be;
      if (i == 0) begin
        addr = a; wren = wr; acc_size = sz; wrap = wp;
      end else begin
        addr     = $urandom;
        wren     = 1'($urandom_range(0, 1));
        acc_size = 2'($urandom_range(0, 3));
        wrap     = 1'($urandom_range(0, 1));
      end
      if (!wr) begin
        exp_q.push_back(oob ? {1'b1, 32'h0} : {1'b0, model[idx]});
        cyc_q.push_back(cyc_cnt + RL);
      end
      @(posedge clock);
      #1;
      if (wr) begin
        check("wr_err", err, oob);
        if (!oob) begin
          nv = model.exists(idx) ? model[idx] : 32'h0;
          for (int j = 0; j < 4; j++) begin
            if (cur_be[j]) nv[31-8*j -: 8] = wbuf[i][31-8*j -: 8];
          end
          model[idx] = nv;
        end
      end
      check("busy", busy, (i < beats - 1));
    end
    enable = 1'b0;
    addr   = $urandom;
    wren   = 1'($urandom_range(0, 1));
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  logic [31:0] ra;
  logic [1:0]  rsz;
  logic        rwp;

  initial begin
    reset = 1'b1; enable = 1'b0; addr = '0; wren = 1'b0; acc_size = '0;
    wrap = 1'b0; cur_be = '1; byte_en = '1; data_in = '0;
    repeat (3) @(posedge clock);
    #1;
    check("rst_dout",  data_out,   0);
    check("rst_valid", data_valid, 0);
    check("rst_busy",  busy,       0);
    check("rst_err",   err,        0);
    reset = 1'b0;
    @(posedge clock);
    #1;

    // Single write then single read.
    wbuf[0] = 32'h3C1D8002;
    run_burst(1'b1, 32'h80020000, 2'd0, 1'b0, -1, 0, -1);
    run_burst(1'b0, 32'h80020000, 2'd0, 1'b0, -1, 0, -1);

    // Four-beat incrementing write and read-back.
    wbuf[0] = 32'h11111111; wbuf[1] = 32'h22222222;
    wbuf[2] = 32'h33333333; wbuf[3] = 32'h44444444;
    run_burst(1'b1, 32'h80020004, 2'd1, 1'b0, -1, 0, -1);
    run_burst(1'b0, 32'h80020004, 2'd1, 1'b0, -1, 0, -1);

    // Sixteen-beat write with a two-cycle stall after beat 5; the read-back
    // stalls too, so data_valid gaps appear.
    for (int i = 0; i < 16; i++) wbuf[i] = $urandom;
    run_burst(1'b1, 32'h80020040, 2'd3, 1'b0, 6, 2, -1);
    run_burst(1'b0, 32'h80020040, 2'd3, 1'b0, 3, 2, -1);

    // Wrap read: fill words 0..7 of the block, then start at word 6.
    for (int i = 0; i < 8; i++) wbuf[i] = 32'(i);
    run_burst(1'b1, 32'h80020040, 2'd2, 1'b0, -1, 0, -1);
    run_burst(1'b0, 32'h80020058, 2'd2, 1'b1, -1, 0, -1);

    // Byte-lane masking.
    wbuf[0] = 32'hAABBCCDD;
    run_burst(1'b1, 32'h80020100, 2'd0, 1'b0, -1, 0, -1);
    wbuf[0] = 32'h00000000; cur_be = 4'b0101;
    run_burst(1'b1, 32'h80020100, 2'd0, 1'b0, -1, 0, -1);
    cur_be = '1;
    run_burst(1'b0, 32'h80020100, 2'd0, 1'b0, -1, 0, -1);

    // Window edges: a read below the base, then a write that runs off the top.
    run_burst(1'b0, 32'h8001FFFC, 2'd0, 1'b0, -1, 0, -1);
    for (int i = 0; i < 4; i++) wbuf[i] = $urandom;
    run_burst(1'b1, 32'h8011FFFC, 2'd1, 1'b0, -1, 0, -1);
    run_burst(1'b0, 32'h8011FFFC, 2'd0, 1'b0, -1, 0, -1);
    run_burst(1'b0, 32'h80120000, 2'd0, 1'b0, -1, 0, -1);

    // Random bursts in a scratch region, each read back with the same shape.
    for (int k = 0; k < 6; k++) begin
      ra  = 32'h80020200 + 32'($urandom_range(0, 63)) * 4;
      rsz = 2'($urandom_range(0, 3));
      rwp = 1'($urandom_range(0, 1));
      for (int i = 0; i < 16; i++) wbuf[i] = $urandom;
      run_burst(1'b1, ra, rsz, rwp, -1, 0, -1);
      run_burst(1'b0, ra, rsz, rwp, int'($urandom_range(1, 3)), 1, -1);
    end

    // Reset in the middle of a 16-beat read, then a normal request.
    run_burst(1'b0, 32'h80020040, 2'd3, 1'b0, -1, 0, 5);
    run_burst(1'b0, 32'h80020000, 2'd0, 1'b0, -1, 0, -1);

    enable = 1'b0;
    repeat (RL + 3) @(posedge clock);
    #2;
    check("drain", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/burst_main_mem.md
Name: burst_main_mem

Overview:
- Parametrised successor of the main memory model: word-addressed backing store behind a byte-address window starting at BASE_ADDR.
- Supports single and burst reads/writes with configurable width, depth, burst range and read latency.
- Adds byte-lane write masking, wrap bursts, a read-data valid strobe, out-of-range error reporting and enable-driven stall.
- Sits between the fetch/load-store stages and the bench loader; same clock domain as the processor core.

Parameters:
DATA_WIDTH, 32, word width in bits; multiple of 8
ADDR_WIDTH, 32, byte address width
DEPTH_WORDS, 262144, number of words stored (1 MiB at 32 bits)
BASE_ADDR, 32'h80020000, byte address of word 0
ACC_W, 2, acc_size width; max burst = 2^(2^ACC_W - 1 + 1) words (16 at ACC_W=2)
READ_LATENCY, 1, cycles from read beat to data_out; must be >= 1

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high
enable  in  1  request qualifier; low during a burst stalls it
addr  in  ADDR_WIDTH  byte address; low log2(DATA_WIDTH/8) bits ignored
wren  in  1  1 = write, 0 = read; sampled at acceptance
acc_size  in  ACC_W  burst code: 0 -> 1 beat, k>0 -> 2^(k+1) beats
wrap  in  1  1 = wrap within burst-aligned block, 0 = incrementing; sampled at acceptance
byte_en  in  DATA_WIDTH/8  write lane mask; lane 0 = data_in[0:7] (bit 0 is MSB)
data_in  in  DATA_WIDTH  write data, one word per beat
data_out  out  DATA_WIDTH  read data
data_valid  out  1  data_out holds a read beat this cycle
busy  out  1  burst in progress; new requests ignored
err  out  1  current beat address outside window

Behaviour:
- Reset (async): state IDLE; data_out=0, data_valid=0, busy=0, err=0, read pipeline flushed. Memory contents are NOT cleared. Reset mid-burst abandons remaining beats; undelivered read beats are never delivered.
- States: IDLE, WBURST, RBURST.
- Acceptance: on a rising edge in IDLE with enable=1, latch addr, wren, acc_size, wrap. Beat 0 executes in the acceptance cycle, and write beat 0 uses data_in/byte_en of that edge.
- If beats > 1: go to WBURST/RBURST with busy=1 from the next cycle. Otherwise stay IDLE and busy never asserts.
- Burst beats: one beat per edge while enable=1. With enable=0 the beat is not consumed, the address counter holds and busy stays 1. Write data must be held while stalled.
- After the final beat is consumed: return to IDLE; busy=0 next cycle. A request is acceptable on the first edge with busy=0. Requests presented while busy=1 are ignored, with no queuing.
- Beat address, incrementing: start_word + i.
- Beat address, wrap: block aligned to beats*DATA_WIDTH/8 bytes; the index within the block is (start_index + i) mod beats. For example, a start at word 6 of an 8-word block gives words 6,7,0,1,...
- Writes: each lane with byte_en=1 is updated at the beat edge; other lanes are unchanged.
- Reads: the array is sampled at the beat edge. data_out/data_valid appear READ_LATENCY cycles later, one word per consumed beat, in beat order.
  - Stalled cycles produce data_valid=0 gaps.
  - data_out holds its last value when data_valid=0.
  - Pipeline drain may overlap a following request.
- Read-after-write ordering: a read beat sees all writes at earlier edges. A same-edge write to the same word is not visible; the read returns the old value.
- Range: word index = (beat_addr - BASE_ADDR) >> log2(DATA_WIDTH/8). A beat address below BASE_ADDR or with index >= DEPTH_WORDS is an error:
  - write beat: suppressed, err=1 for one cycle;
  - read beat: returns all zeros with data_valid=1 and err aligned with that data_valid.
  - Incrementing bursts crossing the top flag only the overflowing beats.
- Subtraction is done at ADDR_WIDTH with no wrap into valid range.

Test Plan:
- Single write 0x3C1D8002 to 0x80020000 with byte_en=all-ones, then single read -> data_valid=1 with data_out=0x3C1D8002 READ_LATENCY cycles after the read edge; busy stays 0 throughout.
- Write burst acc_size=1 (4 beats) at 0x80020004 with words 0x11111111..0x44444444, then read burst -> busy=1 for 3 cycles each time; 4 consecutive data_valid beats returning the words in order.
- Write burst acc_size=3 (16 beats) at 0x80020040 with enable dropped for 2 cycles after beat 5 -> busy held; the read-back of all 16 words matches, with no duplicate or skipped words.
- Wrap read acc_size=2 (8 beats) starting 0x80020058 after filling 0x80020040..5C with 0..7 -> data_out sequence 6,7,0,1,2,3,4,5.
- Write 0xAABBCCDD, then write 0x00000000 with byte_en=4'b0101 to the same word -> read returns 0xAA00CC00.
- Read at 0x8001FFFC and a 4-beat incrementing write starting at the last valid word -> read returns 0 with err=1. For the write, only beats 1-3 flag err and only the last valid word is modified. Asserting reset mid 16-beat read -> all outputs 0 immediately; the next request is accepted normally.
